dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 45 ++++
 rtl/dmem_arbiter.sv | 94 +++++++++
 tb/tb_dmem_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports, the shared response data and the data memory side.
// slave is the arbiter's view; master is the view of the requesters and memory.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              r0_valid;
  logic              r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_ready;
  logic              r0_rsp_valid;
  logic              r0_rsp_ready;

  logic              r1_valid;
  logic              r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_ready;
  logic              r1_rsp_valid;
  logic              r1_rsp_ready;

  logic [DATA_W-1:0] rsp_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  r0_valid, r0_we, r0_addr, r0_wdata, r0_rsp_ready,
    input  r1_valid, r1_we, r1_addr, r1_wdata, r1_rsp_ready,
    input  mem_rdata,
    output r0_ready, r0_rsp_valid, r1_ready, r1_rsp_valid,
    output rsp_rdata, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output r0_valid, r0_we, r0_addr, r0_wdata, r0_rsp_ready,
    output r1_valid, r1_we, r1_addr, r1_wdata, r1_rsp_ready,
    output mem_rdata,
    input  r0_ready, r0_rsp_valid, r1_ready, r1_rsp_valid,
    input  rsp_rdata, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data memory arbiter (CPU port 0, DMA/debug port 1): IDLE -> ISSUE -> [RESP].
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; otherwise port 0 wins.
module dmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state, state_nx;
  logic              any_req;
  logic              sel;
  logic              grant;
  logic              owner_p0;
  logic              we_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [DATA_W-1:0] rdata_p1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic              last_gnt;
`endif

  always_comb begin
    any_req = bus.r0_valid | bus.r1_valid;
    sel     = 1'b0;
    if (bus.r0_valid && bus.r1_valid) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      sel = ~last_gnt;
`else
      sel = 1'b0;
`endif
    end else begin
      sel = bus.r1_valid;
    end
    grant = (state == IDLE) && any_req;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = ISSUE;
      ISSUE:   state_nx = we_p0 ? IDLE : RESP;
      RESP:    if (owner_p0 ? bus.r1_rsp_ready : bus.r0_rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Stage p0: request latched at grant; stage p1: read data captured at end of ISSUE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_p0 <= 1'b0;
      we_p0    <= 1'b0;
      addr_p0  <= '0;
      wdata_p0 <= '0;
      rdata_p1 <= '0;
    end else begin
      if (grant) begin
        owner_p0 <= sel;
        we_p0    <= sel ? bus.r1_we    : bus.r0_we;
        addr_p0  <= sel ? bus.r1_addr  : bus.r0_addr;
        wdata_p0 <= sel ? bus.r1_wdata : bus.r0_wdata;
      end
      if (state == ISSUE && !we_p0) rdata_p1 <= bus.mem_rdata;
    end
  end

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // Reset value 1 means "port 1 granted last", so port 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_gnt <= 1'b1;
    else if (grant) last_gnt <= sel;
  end
`endif

  assign bus.r0_ready     = grant & ~sel;
  assign bus.r1_ready     = grant & sel;
  assign bus.mem_we       = (state == ISSUE) & we_p0;
  assign bus.mem_addr     = addr_p0;
  assign bus.mem_wdata    = wdata_p0;
  assign bus.rsp_rdata    = rdata_p1;
  assign bus.r0_rsp_valid = (state == RESP) & ~owner_p0;
  assign bus.r1_rsp_valid = (state == RESP) & owner_p0;
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected grants and memory/response events,
// a negedge monitor pops and compares them whenever the DUT presents a grant, write or response.
module tb_dmem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [DW-1:0] mem [0:255];
  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;

  typedef struct packed {
    logic          rd;
    logic          port;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  ev_t  evq[$];
  logic gq[$];
  ev_t  mon_e;
  logic mon_g;
  int   total = 0;
  int   bad = 0;

  function automatic ev_t mk(input logic rd, input logic port, input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
    ev_t e;
    e.rd = rd; e.port = port; e.addr = a; e.data = d;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic expect_none(input string nm);
    total++;
    bad++;
    $display("FAIL %s: unexpected DUT event at %0t", nm, $time);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.r0_ready || bus.r1_ready) begin
        if (gq.size() == 0) expect_none("grant");
        else begin
          mon_g = gq.pop_front();
          chk("grant_port", {31'd0, bus.r1_ready}, {31'd0, mon_g});
          chk("grant_onehot", {31'd0, bus.r0_ready & bus.r1_ready}, 32'd0);
        end
      end
      if (bus.mem_we) begin
        if (evq.size() == 0) expect_none("mem_write");
        else begin
          mon_e = evq.pop_front();
          chk("wr_kind", {31'd0, mon_e.rd}, 32'd0);
          chk("wr_addr", {16'd0, bus.mem_addr}, {16'd0, mon_e.addr});
          chk("wr_data", {16'd0, bus.mem_wdata}, {16'd0, mon_e.data});
        end
      end
      if ((bus.r0_rsp_valid && bus.r0_rsp_ready) || (bus.r1_rsp_valid && bus.r1_rsp_ready)) begin
        if (evq.size() == 0) expect_none("read_rsp");
        else begin
          mon_e = evq.pop_front();
          chk("rd_kind", {31'd0, mon_e.rd}, 32'd1);
          chk("rd_port", {31'd0, bus.r1_rsp_valid}, {31'd0, mon_e.port});
          chk("rd_data", {16'd0, bus.rsp_rdata}, {16'd0, mon_e.data});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    if (p == 0) begin
      bus.r0_valid = v; bus.r0_we = we; bus.r0_addr = a; bus.r0_wdata = d;
    end else begin
      bus.r1_valid = v; bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = d;
    end
  endtask

  task automatic wait_ready(input int p, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = (p == 0) ? bus.r0_ready : bus.r1_ready;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL ready_timeout: port %0d not granted within 20 cycles", p);
    end
  endtask

  task automatic issue(input int p, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int n);
    set_req(p, 1'b1, we, a, d);
    wait_ready(p, n);
    tick();
    set_req(p, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    int n;
    int cnt;
    int cyc;
    logic g;
    bus.r0_rsp_ready = 1'b0;
    bus.r1_rsp_ready = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);

    #12;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_rsp_valid", {30'd0, bus.r1_rsp_valid, bus.r0_rsp_valid}, 32'd0);
    chk("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
    chk("rst_mem_wdata", {16'd0, bus.mem_wdata}, 32'd0);
    chk("rst_rsp_rdata", {16'd0, bus.rsp_rdata}, 32'd0);
    tick();
    rst_n = 1'b1;

    // r0 write 0x0010 <= 0xBEEF
    tick();
    gq.push_back(1'b0);
    evq.push_back(mk(1'b0, 1'b0, 16'h0010, 16'hBEEF));
    issue(0, 1'b1, 16'h0010, 16'hBEEF, n);
    chk("w_ready_cycle0", n, 32'd1);
    @(negedge clk);
    chk("w_mem_we_c1", {31'd0, bus.mem_we}, 32'd1);
    chk("w_mem_addr_c1", {16'd0, bus.mem_addr}, 32'h0010);
    chk("w_busy_c1", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    chk("w_busy_c2", {31'd0, bus.busy}, 32'd0);
    chk("w_mem_we_c2", {31'd0, bus.mem_we}, 32'd0);

    // r1 read 0x0010 -> 0xBEEF two cycles after acceptance
    tick();
    bus.r1_rsp_ready = 1'b1;
    gq.push_back(1'b1);
    evq.push_back(mk(1'b1, 1'b1, 16'h0010, 16'hBEEF));
    issue(1, 1'b0, 16'h0010, 16'h0000, n);
    chk("r_ready_cycle0", n, 32'd1);
    @(negedge clk);
    chk("r_rsp_valid_c1", {31'd0, bus.r1_rsp_valid}, 32'd0);
    chk("r_mem_we_c1", {31'd0, bus.mem_we}, 32'd0);
    @(negedge clk);
    chk("r_rsp_valid_c2", {31'd0, bus.r1_rsp_valid}, 32'd1);
    chk("r_rdata_c2", {16'd0, bus.rsp_rdata}, 32'hBEEF);
    chk("r_nonowner_c2", {31'd0, bus.r0_rsp_valid}, 32'd0);
    @(negedge clk);
    chk("r_busy_c3", {31'd0, bus.busy}, 32'd0);

    // r1 write 0x0020 <= 0x1234
    tick();
    gq.push_back(1'b1);
    evq.push_back(mk(1'b0, 1'b1, 16'h0020, 16'h1234));
    issue(1, 1'b1, 16'h0020, 16'h1234, n);
    @(negedge clk);
    @(negedge clk);

    // r0 read stalled 5 cycles with r1 write pending behind it
    tick();
    bus.r0_rsp_ready = 1'b0;
    gq.push_back(1'b0);
    evq.push_back(mk(1'b1, 1'b0, 16'h0020, 16'h1234));
    gq.push_back(1'b1);
    evq.push_back(mk(1'b0, 1'b1, 16'h0030, 16'h5555));
    set_req(1, 1'b1, 1'b1, 16'h0030, 16'h5555);
    issue(0, 1'b0, 16'h0020, 16'h0000, n);
    chk("stall_ready_cycle0", n, 32'd1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", {31'd0, bus.r0_rsp_valid}, 32'd1);
      chk("stall_rdata", {16'd0, bus.rsp_rdata}, 32'h1234);
      chk("stall_r1_ready", {31'd0, bus.r1_ready}, 32'd0);
      chk("stall_r1_rsp_valid", {31'd0, bus.r1_rsp_valid}, 32'd0);
    end
    tick();
    bus.r0_rsp_ready = 1'b1;
    wait_ready(1, n);
    chk("stall_r1_grant_lat", n, 32'd2);
    tick();
    set_req(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);

    // Both ports request continuously
    tick();
    for (int k = 0; k < 4; k++) begin
      g = RR ? k[0] : 1'b0;
      gq.push_back(g);
      evq.push_back(mk(1'b0, g, g ? 16'h0050 : 16'h0040, g ? 16'h0B0B : 16'h0A0A));
    end
    set_req(0, 1'b1, 1'b1, 16'h0040, 16'h0A0A);
    set_req(1, 1'b1, 1'b1, 16'h0050, 16'h0B0B);
    cnt = 0;
    cyc = 0;
    while (cnt < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.r0_ready || bus.r1_ready) cnt++;
    end
    chk("contend_grants", cnt, 32'd4);
    chk("write_throughput", cyc, 32'd7);
    tick();
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);

    // Reset asserted during ISSUE: port 0 write, then port 1 read
    for (int t = 0; t < 2; t++) begin
      tick();
      gq.push_back(t[0]);
      set_req(t, 1'b1, (t == 0), 16'h0060, 16'h7777);
      wait_ready(t, n);
      tick();
      set_req(t, 1'b0, 1'b0, '0, '0);
      chk("abort_mem_we_issue", {31'd0, bus.mem_we}, (t == 0) ? 32'd1 : 32'd0);
      chk("abort_busy_issue", {31'd0, bus.busy}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_mem_we_async", {31'd0, bus.mem_we}, 32'd0);
      chk("abort_busy_async", {31'd0, bus.busy}, 32'd0);
      chk("abort_mem_addr_async", {16'd0, bus.mem_addr}, 32'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("abort_busy_after", {31'd0, bus.busy}, 32'd0);
        chk("abort_rsp_after", {30'd0, bus.r1_rsp_valid, bus.r0_rsp_valid}, 32'd0);
      end
    end

    chk("events_left", evq.size(), 32'd0);
    chk("grants_left", gq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
